// File: rtl/pisa_sequencer.sv
// -----------------------------------------------------------------------------
// pisa_sequencer
//   Multi-cycle instruction sequencer for the PISA core. Owns the program
//   counter and walks each instruction through FETCH -> DECODE -> EXECUTE ->
//   (MEM) -> (WRITEBACK). The CU gets one DECODE cycle to settle. Branch
//   outcomes come from the ALU flags sampled in EXECUTE. A CU halt parks the
//   core in HALT until reset.
//
// Ports
//   clk, rst_n        core clock (rising edge), asynchronous active-low reset
//   imem_req/addr/ack instruction fetch handshake; imem_addr is always pc
//   ir_load           one-cycle pulse telling the datapath to latch IR
//   halt              CU halt request (hlt or illegal opcode)
//   wr_src, wm_src    CU register / memory write sources (0 = none, wr_src 3 = load)
//   jmp_src, jmp_cond CU jump source (0 = no jump) and condition code
//   alu_zero, alu_neg ALU flags used for conditional jumps
//   jmp_target        resolved jump target from the datapath
//   dmem_req/we/ack   data memory handshake (we: 1 store, 0 load)
//   reg_we            register file write enable
//   retire            one-cycle pulse when an instruction completes
//   halted            core is parked in HALT
//   pc                current program counter
// -----------------------------------------------------------------------------
module pisa_sequencer #(
  parameter int                ADDR_W      = 32,
  parameter int                INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              ir_load,
  input  logic              halt,
  input  logic [2:0]        wr_src,
  input  logic [1:0]        wm_src,
  input  logic [1:0]        jmp_src,
  input  logic [2:0]        jmp_cond,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              reg_we,
  output logic              retire,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  // run_q keeps every request low while reset is held and for the first
  // edge after release, so the first fetch appears one cycle after release.
  logic              run_q, run_d;

  logic [ADDR_W-1:0] pc_seq;
  logic              taken_now;
  logic              is_store;

  function automatic logic cond_met(input logic [2:0] code,
                                    input logic       zero,
                                    input logic       neg);
    logic met;
    met = 1'b0;
    case (code)
      3'b000:  met = 1'b1;
      3'b010:  met = zero;
      3'b011:  met = ~zero;
      3'b100:  met = neg;
      3'b101:  met = ~neg;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

  assign pc_seq    = pc_q + ADDR_W'(INSTR_BYTES);
  assign taken_now = (jmp_src != 2'd0) && cond_met(jmp_cond, alu_zero, alu_neg);
  assign is_store  = (wm_src != 2'd0);

  assign pc        = pc_q;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    taken_d  = taken_q;
    run_d    = 1'b1;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end
        end
      end

      S_DECODE: begin
        state_d = halt ? S_HALT : S_EXECUTE;
      end

      S_EXECUTE: begin
        taken_d = taken_now;
        if (is_store || (wr_src == 3'd3)) begin
          state_d = S_MEM;
        end else if (wr_src != 3'd0) begin
          state_d = S_WRITEBACK;
        end else begin
          // Pure jump / no-op: retires here, so use the fresh decision
          // rather than the registered copy.
          state_d = S_FETCH;
          retire  = 1'b1;
          pc_d    = taken_now ? jmp_target : pc_seq;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            state_d = S_FETCH;
            retire  = 1'b1;
            pc_d    = taken_q ? jmp_target : pc_seq;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end

      S_WRITEBACK: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        pc_d    = taken_q ? jmp_target : pc_seq;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_pisa_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pisa_sequencer
//   Self-checking bench for pisa_sequencer: a table of hand-computed
//   instructions, hand-written reset/halt sequences and a randomized run
//   checked against a per-instruction behavioural model.
// -----------------------------------------------------------------------------
module tb_pisa_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        ir_load;
  logic        halt;
  logic [2:0]  wr_src;
  logic [1:0]  wm_src;
  logic [1:0]  jmp_src;
  logic [2:0]  jmp_cond;
  logic        alu_zero;
  logic        alu_neg;
  logic [31:0] jmp_target;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        reg_we;
  logic        retire;
  logic        halted;
  logic [31:0] pc;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pisa_sequencer #(.ADDR_W(32), .INSTR_BYTES(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .ir_load(ir_load), .halt(halt),
    .wr_src(wr_src), .wm_src(wm_src), .jmp_src(jmp_src), .jmp_cond(jmp_cond),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .jmp_target(jmp_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_we(reg_we), .retire(retire), .halted(halted), .pc(pc)
  );

  typedef struct {
    logic [2:0]  wr;
    logic [1:0]  wm;
    logic [1:0]  js;
    logic [2:0]  jc;
    logic        z;
    logic        n;
    logic        h;
    logic [31:0] tgt;
    int          fwait;
    int          mwait;
  } instr_t;

  typedef struct {
    int          cycles;
    int          we;
    int          we_at;
    int          dreq;
    int          irl;
    logic        sawwe;
    logic        halted;
    logic        done;
    logic [31:0] pc;
  } res_t;

  typedef struct {
    instr_t      in;
    int          cycles;
    int          we;
    int          dreq;
    logic        sawwe;
    logic [31:0] pc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [2:0] wr, input logic [1:0] wm,
                                input logic [1:0] js, input logic [2:0] jc,
                                input logic z, input logic n, input logic [31:0] tgt,
                                input int fw, input int mw);
    instr_t i;
    i.wr = wr; i.wm = wm; i.js = js; i.jc = jc; i.z = z; i.n = n; i.h = 1'b0;
    i.tgt = tgt; i.fwait = fw; i.mwait = mw;
    return i;
  endfunction

  // Behavioural model: whole-instruction outcome from the instruction's class.
  function automatic res_t model(input instr_t i, input logic [31:0] pc0);
    res_t e;
    bit   cond, taken, st, ld, wb;
    int   mc;
    e = '{default: 0};
    e.irl = 1;
    if (i.h) begin
      e.halted = 1'b1;
      e.cycles = i.fwait + 3;
      e.pc     = pc0;
      return e;
    end
    case (i.jc)
      3'd0:    cond = 1'b1;
      3'd2:    cond = i.z;
      3'd3:    cond = !i.z;
      3'd4:    cond = i.n;
      3'd5:    cond = !i.n;
      default: cond = 1'b0;
    endcase
    taken    = (i.js != 0) && cond;
    st       = (i.wm != 0);
    ld       = !st && (i.wr == 3);
    wb       = !st && (i.wr != 0);
    mc       = (st || ld) ? i.mwait + 1 : 0;
    e.done   = 1'b1;
    e.cycles = (i.fwait + 1) + 1 + 1 + mc + (wb ? 1 : 0);
    e.we     = wb ? 1 : 0;
    e.we_at  = wb ? e.cycles : 0;
    e.dreq   = mc;
    e.sawwe  = st;
    e.pc     = taken ? i.tgt : pc0 + 32'd4;
    return e;
  endfunction

  // Entered at posedge+1 with the DUT in FETCH; returns at posedge+1 after
  // the instruction retires (or the core halts).
  task automatic run_instr(input instr_t in, output res_t r);
    int fc, mc;
    r  = '{default: 0};
    fc = 0;
    mc = 0;
    wr_src = in.wr; wm_src = in.wm; jmp_src = in.js; jmp_cond = in.jc;
    alu_zero = in.z; alu_neg = in.n; halt = in.h; jmp_target = in.tgt;
    for (int c = 0; c < 300; c++) begin
      imem_ack = imem_req && (fc == in.fwait);
      if (imem_req) fc++;
      dmem_ack = dmem_req && (mc == in.mwait);
      if (dmem_req) mc++;
      @(negedge clk);
      r.cycles++;
      if (reg_we) begin r.we++; r.we_at = r.cycles; end
      if (dmem_req) begin r.dreq++; if (dmem_we) r.sawwe = 1'b1; end
      if (ir_load) r.irl++;
      if (retire) r.done = 1'b1;
      if (halted) r.halted = 1'b1;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (r.done || r.halted) break;
    end
    r.pc = pc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_outputs", {imem_req, ir_load, dmem_req, dmem_we, reg_we, retire, halted}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_imem_req", imem_req, 1'b1);
    chk("rel_imem_addr", imem_addr, 32'h0);
  endtask

  vec_t        tbl[14];
  res_t        r, e;
  instr_t      ri;
  logic [31:0] exp_pc;
  logic [31:0] frozen;
  int          bad;
  bit          seen;
  int unsigned tmp;

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; halt = 1'b0;
    wr_src = '0; wm_src = '0; jmp_src = '0; jmp_cond = '0;
    alu_zero = 1'b0; alu_neg = 1'b0; jmp_target = '0;

    //           wr    wm    js    jc     z  n  target        fw mw   cyc we dreq we? pc
    tbl[0]  = '{mk(3'd1, 2'd0, 2'd0, 3'b000, 0, 0, 32'h0,        0, 0), 4, 1, 0, 0, 32'h4};
    tbl[1]  = '{mk(3'd0, 2'd0, 2'd2, 3'b010, 1, 0, 32'h40,       0, 0), 3, 0, 0, 0, 32'h40};
    tbl[2]  = '{mk(3'd0, 2'd0, 2'd2, 3'b010, 0, 0, 32'h80,       0, 0), 3, 0, 0, 0, 32'h44};
    tbl[3]  = '{mk(3'd0, 2'd0, 2'd2, 3'b001, 1, 0, 32'h100,      0, 0), 3, 0, 0, 0, 32'h48};
    tbl[4]  = '{mk(3'd0, 2'd0, 2'd1, 3'b000, 0, 0, 32'hFFFFFFFC, 0, 0), 3, 0, 0, 0, 32'hFFFFFFFC};
    tbl[5]  = '{mk(3'd1, 2'd0, 2'd0, 3'b000, 0, 0, 32'h0,        0, 0), 4, 1, 0, 0, 32'h0};
    tbl[6]  = '{mk(3'd3, 2'd0, 2'd0, 3'b000, 0, 0, 32'h0,        0, 3), 8, 1, 4, 0, 32'h4};
    tbl[7]  = '{mk(3'd0, 2'd1, 2'd0, 3'b000, 0, 0, 32'h0,        0, 0), 4, 0, 1, 1, 32'h8};
    tbl[8]  = '{mk(3'd1, 2'd0, 2'd0, 3'b000, 0, 0, 32'h0,        2, 0), 6, 1, 0, 0, 32'hC};
    tbl[9]  = '{mk(3'd0, 2'd0, 2'd1, 3'b100, 0, 1, 32'h200,      0, 0), 3, 0, 0, 0, 32'h200};
    tbl[10] = '{mk(3'd0, 2'd0, 2'd1, 3'b101, 0, 1, 32'h280,      0, 0), 3, 0, 0, 0, 32'h204};
    tbl[11] = '{mk(3'd0, 2'd0, 2'd3, 3'b011, 0, 0, 32'h300,      0, 0), 3, 0, 0, 0, 32'h300};
    tbl[12] = '{mk(3'd1, 2'd0, 2'd0, 3'b000, 1, 1, 32'h400,      0, 0), 4, 1, 0, 0, 32'h304};
    tbl[13] = '{mk(3'd3, 2'd0, 2'd1, 3'b000, 0, 0, 32'h500,      0, 1), 6, 1, 2, 0, 32'h500};

    do_reset();

    foreach (tbl[k]) begin
      run_instr(tbl[k].in, r);
      chk($sformatf("tbl%0d_done", k),   r.done,   1'b1);
      chk($sformatf("tbl%0d_cycles", k), r.cycles, tbl[k].cycles);
      chk($sformatf("tbl%0d_reg_we", k), r.we,     tbl[k].we);
      chk($sformatf("tbl%0d_we_at", k),  r.we_at,  (tbl[k].we != 0) ? tbl[k].cycles : 0);
      chk($sformatf("tbl%0d_dreq", k),   r.dreq,   tbl[k].dreq);
      chk($sformatf("tbl%0d_dmem_we", k), r.sawwe, tbl[k].sawwe);
      chk($sformatf("tbl%0d_pc", k),     r.pc,     tbl[k].pc);
    end

    // Halt in DECODE: core parks, pc frozen, spurious acks ignored.
    ri   = mk(3'd1, 2'd1, 2'd1, 3'b000, 0, 0, 32'h1234, 0, 0);
    ri.h = 1'b1;
    run_instr(ri, r);
    chk("halt_halted", r.halted, 1'b1);
    chk("halt_cycles", r.cycles, 3);
    chk("halt_pc", r.pc, 32'h500);
    frozen = 32'h500;
    bad    = 0;
    for (int c = 0; c < 100; c++) begin
      imem_ack = $urandom_range(0, 1);
      dmem_ack = $urandom_range(0, 1);
      @(negedge clk);
      if (!halted || imem_req || dmem_req || reg_we || retire || ir_load || pc != frozen) bad++;
      @(posedge clk);
      #1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("halt_hold_violations", bad, 0);

    // Reset during a MEM wait: dmem_req drops while the clock is still low.
    do_reset();
    run_instr(mk(3'd1, 2'd0, 2'd0, 3'b000, 0, 0, 32'h0, 0, 0), r);
    chk("pre_mem_pc", r.pc, 32'h4);
    wr_src = 3'd3; wm_src = '0; jmp_src = '0; halt = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      @(negedge clk);
      if (dmem_req) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    imem_ack = 1'b0;
    chk("mem_reached", seen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dmem_req_drop", dmem_req, 1'b0);
    chk("async_pc_reset", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_imem_req", imem_req, 1'b1);
    chk("restart_imem_addr", imem_addr, 32'h0);

    // Randomized instruction stream against the model.
    exp_pc = 32'h0;
    for (int k = 0; k < 200; k++) begin
      ri.wr    = 3'($urandom_range(0, 7));
      ri.wm    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      ri.js    = 2'($urandom_range(0, 3));
      ri.jc    = 3'($urandom_range(0, 7));
      ri.z     = 1'($urandom_range(0, 1));
      ri.n     = 1'($urandom_range(0, 1));
      ri.h     = 1'b0;
      tmp      = $urandom();
      ri.tgt   = tmp & 32'hFFFFFFFC;
      ri.fwait = $urandom_range(0, 3);
      ri.mwait = $urandom_range(0, 3);
      chk($sformatf("rnd%0d_imem_addr", k), imem_addr, exp_pc);
      e = model(ri, exp_pc);
      run_instr(ri, r);
      chk($sformatf("rnd%0d_done", k),    r.done,   e.done);
      chk($sformatf("rnd%0d_cycles", k),  r.cycles, e.cycles);
      chk($sformatf("rnd%0d_reg_we", k),  r.we,     e.we);
      chk($sformatf("rnd%0d_we_at", k),   r.we_at,  e.we_at);
      chk($sformatf("rnd%0d_dreq", k),    r.dreq,   e.dreq);
      chk($sformatf("rnd%0d_dmem_we", k), r.sawwe,  e.sawwe);
      chk($sformatf("rnd%0d_ir_load", k), r.irl,    e.irl);
      chk($sformatf("rnd%0d_pc", k),      r.pc,     e.pc);
      exp_pc = e.pc;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
